// File: rtl/peripheral_wifi_rx.sv
// peripheral_wifi_rx: J1 IO-bus receiver for the WiFi module's 8N1 serial reply stream.
// Received bytes land in a small FIFO; the CPU pops them through the DATA register,
// watches fill level and line errors in STATUS, and flushes / clears errors via CTRL.
//
// Bus handshake: there is no valid/ready pair on this bus. cs qualifies every access;
// rd and wr are single-cycle strobes that take effect on the rising clock edge in which
// they are high, and d_out is combinational so read data is valid in that same cycle.
module peripheral_wifi_rx #(
    parameter int clkFreq  = 50000000,
    parameter int baudRate = 115200,
    parameter int FIFO_AW  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] d_in,
    input  logic        cs,
    input  logic [3:0]  addr,
    input  logic        rd,
    input  logic        wr,
    output logic [15:0] d_out,
    input  logic        rx,
    output logic        rx_irq,
    output logic [1:0]  dbg_state
);

    localparam int DIV   = clkFreq / baudRate;
    localparam int HALF  = DIV / 2;
    localparam int CW    = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int DEPTH = 2 ** FIFO_AW;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t state, state_next;

    // Serial-side datapath
    logic             rx_s1, rx_sync, rx_d;
    logic             rx_fall;
    logic [CW-1:0]    baud_cnt;
    logic             baud_tick;
    logic             half_tick;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;

    // FSM decoded actions
    logic             shift_en;
    logic             push_req;
    logic             ferr_set;

    // FIFO
    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               empty, full;
    logic [7:0]         head_byte;

    // Bus-side decode
    logic pop_req, flush, err_clr;
    logic do_push, do_pop, overrun_set;
    logic overrun, frame_err;
    logic [15:0] status_word;
    logic unused_d_in;

    assign unused_d_in = ^d_in[15:2];

    // Two-flop synchroniser plus one delayed copy for falling-edge detection.
    // All three reset to the idle (high) line level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_s1   <= 1'b1;
            rx_sync <= 1'b1;
            rx_d    <= 1'b1;
        end else begin
            rx_s1   <= rx;
            rx_sync <= rx_s1;
            rx_d    <= rx_sync;
        end
    end

    assign rx_fall   = rx_d & ~rx_sync;
    assign baud_tick = (baud_cnt == CW'(DIV - 1));
    assign half_tick = (baud_cnt == CW'(HALF - 1));

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: begin
                if (rx_fall) begin
                    state_next = S_START;
                end
            end
            S_START: begin
                // Mid start bit: a line that is high again was only a glitch.
                if (half_tick) begin
                    state_next = rx_sync ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (baud_tick && (bit_idx == 3'd7)) begin
                    state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (baud_tick) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // FSM output decode: sampling strobes and end-of-frame outcome.
    always_comb begin
        shift_en  = 1'b0;
        push_req  = 1'b0;
        ferr_set  = 1'b0;
        dbg_state = state;
        unique case (state)
            S_DATA: shift_en = baud_tick;
            S_STOP: begin
                push_req = baud_tick & rx_sync;
                ferr_set = baud_tick & ~rx_sync;
            end
            default: ;
        endcase
    end

    // Baud counter restarts from zero whenever the FSM enters a new state, so the
    // half-bit wait in START lands DATA sampling at mid-bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            baud_cnt <= '0;
        end else if (state_next != state) begin
            baud_cnt <= '0;
        end else if (baud_tick) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + 1'b1;
        end
    end

    // Bit index and LSB-first shift register for the data bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            if (state != S_DATA) begin
                bit_idx <= '0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + 1'b1;
            end
            if (shift_en) begin
                shift_reg <= {rx_sync, shift_reg[7:1]};
            end
        end
    end

    // Bus request decode. Flush dominates push and pop in the same cycle.
    assign empty       = (count == '0);
    assign full        = (count == (FIFO_AW + 1)'(DEPTH));
    assign pop_req     = cs & rd & (addr == 4'd0) & ~empty;
    assign flush       = cs & wr & (addr == 4'd4) & d_in[0];
    assign err_clr     = cs & wr & (addr == 4'd4) & d_in[1];
    assign do_pop      = pop_req & ~flush;
    assign do_push     = push_req & ~flush & (~full | pop_req);
    assign overrun_set = push_req & ~flush & full & ~pop_req;
    assign head_byte   = mem[rd_ptr];

    // FIFO storage. When full with a simultaneous pop, the write lands in the slot
    // being read this cycle, which is safe because the read is combinational.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= shift_reg;
        end
    end

    // FIFO pointers and fill count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (FIFO_AW + 1)'(1);
                2'b01:   count <= count - (FIFO_AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky error flags; a set in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (overrun_set) begin
                overrun <= 1'b1;
            end else if (err_clr) begin
                overrun <= 1'b0;
            end
            if (ferr_set) begin
                frame_err <= 1'b1;
            end else if (err_clr) begin
                frame_err <= 1'b0;
            end
        end
    end

    // Interrupt is a registered copy of "FIFO not empty".
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_irq <= 1'b0;
        end else begin
            rx_irq <= (count != '0);
        end
    end

    // STATUS layout: count in the low bits, then frame_err, then overrun.
    always_comb begin
        status_word                = '0;
        status_word[FIFO_AW:0]     = count;
        status_word[FIFO_AW + 1]   = frame_err;
        status_word[FIFO_AW + 2]   = overrun;
    end

    // Read mux; everything reads zero when not selected.
    always_comb begin
        d_out = 16'h0000;
        if (cs) begin
            unique case (addr)
                4'd0:    d_out = empty ? 16'h8000 : {8'h00, head_byte};
                4'd2:    d_out = status_word;
                default: d_out = 16'h0000;
            endcase
        end
    end

endmodule
